// File: rtl/sat_pkg.sv
// Shared definitions for the SAT clause datapath.
//   NSAT_DEFAULT / LAW_DEFAULT : default literals per clause and literal address width
//   LIT_W                      : width of one literal (address plus negation bit)
//   NEG_BIT                    : position of the negation bit inside a literal
//   lit_width() / neg_pos()    : the same two quantities for any address width
package sat_pkg;
  localparam int NSAT_DEFAULT = 3;
  localparam int LAW_DEFAULT  = 11;
  localparam int LIT_W        = LAW_DEFAULT + 1;
  localparam int NEG_BIT      = LAW_DEFAULT;

  function automatic int lit_width(input int law);
    return law + 1;
  endfunction

  function automatic int neg_pos(input int law);
    return law;
  endfunction
endpackage

// File: rtl/clause_fifo_mem.sv
// Clause storage array: DEPTH entries of WIDTH bits.
//   clk        : write clock
//   we, waddr,
//   wdata      : synchronous write port
//   raddr      : asynchronous read address
//   rdata      : combinational read data
// Contents are never reset; the control logic only reads written entries.
module clause_fifo_mem #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 36
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/clause_literal_sequencer.sv
// Buffers whole clauses and replays them one literal at a time.
//   clk, reset, flush           : clock, synchronous active-high reset, synchronous clear
//   clause_valid_i/ready_o/i    : clause input handshake and flattened clause
//   lit_valid_o/lit_ready_i     : literal output handshake
//   literal_address_out,
//   literal_negation_bit_out,
//   literal_index_out,
//   last_literal_out            : fields of the current literal (0 when idle)
//   count_o                     : number of buffered clauses
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. valid never depends on ready; once raised, the presented data stays
// stable until the transfer completes. Both handshakes are ignored while reset
// or flush is asserted.
module clause_literal_sequencer
  import sat_pkg::*;
#(
  parameter int NSAT                  = NSAT_DEFAULT,
  parameter int LITERAL_ADDRESS_WIDTH = LAW_DEFAULT,
  parameter int DEPTH                 = 4
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          flush,
  input  logic                                          clause_valid_i,
  output logic                                          clause_ready_o,
  input  logic [NSAT*(LITERAL_ADDRESS_WIDTH+1)-1:0]     clause_i,
  output logic                                          lit_valid_o,
  input  logic                                          lit_ready_i,
  output logic [LITERAL_ADDRESS_WIDTH-1:0]              literal_address_out,
  output logic                                          literal_negation_bit_out,
  output logic [((NSAT > 1) ? $clog2(NSAT) : 1)-1:0]    literal_index_out,
  output logic                                          last_literal_out,
  output logic [$clog2(DEPTH+1)-1:0]                    count_o
);
  localparam int LAW  = LITERAL_ADDRESS_WIDTH;
  localparam int LW   = lit_width(LAW);
  localparam int CW   = NSAT * LW;
  localparam int IW   = (NSAT > 1) ? $clog2(NSAT) : 1;
  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH + 1);

  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CNTW-1:0] count;
  logic [IW-1:0]   idx;
  logic [CW-1:0]   head;
  logic [LW-1:0]   cur_lit;
  logic            push, lit_fire, at_last, pop, clear;

  clause_fifo_mem #(.DEPTH(DEPTH), .WIDTH(CW)) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (clause_i),
    .raddr (rd_ptr),
    .rdata (head)
  );

  assign clear    = reset | flush;
  // Ready is forced high during reset; any push it allows is dropped by clear.
  assign clause_ready_o = reset | (count != CNTW'(DEPTH));
  assign lit_valid_o    = (count != '0);

  assign push     = clause_valid_i & clause_ready_o & ~clear;
  assign at_last  = (idx == IW'(NSAT - 1));
  assign lit_fire = lit_valid_o & lit_ready_i & ~clear;
  assign pop      = lit_fire & at_last;

  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      idx    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (lit_fire) begin
        if (at_last) begin
          idx    <= '0;
          rd_ptr <= rd_ptr + PW'(1);
        end else begin
          idx <= idx + IW'(1);
        end
      end
      // Simultaneous push and pop leaves the count unchanged.
      case ({push, pop})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
    end
  end

  assign cur_lit = head[int'(idx)*LW +: LW];
  assign count_o = count;

  assign literal_address_out      = lit_valid_o ? cur_lit[LAW-1:0] : '0;
  assign literal_negation_bit_out = lit_valid_o & cur_lit[neg_pos(LAW)];
  assign literal_index_out        = lit_valid_o ? idx : '0;
  assign last_literal_out         = lit_valid_o & at_last;
endmodule
